multiport_dram_sclk: RTL and testbench

MULTIPORT_DRAM_SCLK -- requirements
Module: multiport_dram_sclk

---
 rtl/multiport_dram_sclk_pkg.sv | 14 +
 rtl/multiport_dram_sclk_rd_port.sv | 79 +++++++
 rtl/multiport_dram_sclk.sv | 125 ++++++++++++
 tb/tb_multiport_dram_sclk.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multiport_dram_sclk_pkg.sv
// Shared definitions for the multiport single-clock RAM: clear-sweep FSM
// encoding and the supported read-latency range.
package multiport_dram_sclk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } clr_state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

endpackage

// File: rtl/multiport_dram_sclk_rd_port.sv
// One read port of the multiport RAM.
// The port takes the raw array word for its address from the top level. It
// substitutes the incoming write data when the write and the read hit the
// same address in the same cycle (write-first mode only), and returns zero
// while a clear sweep is running. The selected word then goes through a one-
// or two-stage pipeline. q only changes when a read completes.
module dram_rd_port
    import multiport_dram_sclk_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int RD_LAT   = 1,
    parameter int WR_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_ena,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              wr_accept,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_busy,
    output logic [DATA_W-1:0] q,
    output logic              dval
);

    logic [DATA_W-1:0] rd_sel;

    // pick the word this read returns: zero during clear, bypass on collision
    always_comb begin
        rd_sel = ram_rdata;
        if (clr_busy) begin
            rd_sel = '0;
        end else if ((WR_FIRST != 0) && wr_accept && (rd_addr == wr_addr)) begin
            rd_sel = wr_data;
        end
    end

    generate
        if (RD_LAT <= RD_LAT_MIN) begin : g_lat1
            // single stage: capture straight into the output register
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q    <= '0;
                    dval <= 1'b0;
                end else begin
                    dval <= rd_ena;
                    if (rd_ena) begin
                        q <= rd_sel;
                    end
                end
            end
        end else begin : g_lat2
            logic              s1_vld;
            logic [DATA_W-1:0] s1_data;

            // two stages: capture, then forward to the output register
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_vld  <= 1'b0;
                    s1_data <= '0;
                    q       <= '0;
                    dval    <= 1'b0;
                end else begin
                    s1_vld <= rd_ena;
                    if (rd_ena) begin
                        s1_data <= rd_sel;
                    end
                    dval <= s1_vld;
                    if (s1_vld) begin
                        q <= s1_data;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/multiport_dram_sclk.sv
// Single-clock RAM with one write port and N_RD independent read ports,
// plus a background sweep that zeroes the whole array on request.
//
// state | meaning
// IDLE  | normal operation, waiting for clr_req
// CLEAR | zeroing one word per clock, external writes dropped
// DONE  | one-cycle clr_done pulse, then back to IDLE
module multiport_dram_sclk
    import multiport_dram_sclk_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int N_RD     = 2,
    parameter int RD_LAT   = 1,
    parameter int WR_FIRST = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_ena,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [N_RD-1:0]          rd_ena,
    input  logic [N_RD*ADDR_W-1:0]   rd_addr,
    output logic [N_RD*DATA_W-1:0]   q,
    output logic [N_RD-1:0]          dval,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done,
    output logic                     wr_drop
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] ram [DEPTH];

    clr_state_t        state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
    logic              wr_accept;

    assign clr_busy  = (state == ST_CLEAR);
    assign clr_done  = (state == ST_DONE);
    assign wr_accept = wr_ena & ~clr_busy;

    // clear FSM state and sweep address register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // clear FSM next state; the last address is written on the way to DONE
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            ST_IDLE: begin
                if (clr_req) begin
                    state_nxt   = ST_CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            ST_CLEAR: begin
                clr_cnt_nxt = clr_cnt + ADDR_W'(1);
                if (clr_cnt == {ADDR_W{1'b1}}) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // array write: the sweep owns the write port while clearing; contents are never reset
    always_ff @(posedge clk) begin
        if (clr_busy) begin
            ram[clr_cnt] <= '0;
        end else if (wr_accept) begin
            ram[wr_addr] <= wr_data;
        end
    end

    // flag a write that arrived during the sweep and was thrown away
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= wr_ena & clr_busy;
        end
    end

    generate
        for (genvar i = 0; i < N_RD; i++) begin : g_rd
            logic [ADDR_W-1:0] port_addr;
            assign port_addr = rd_addr[i*ADDR_W +: ADDR_W];

            dram_rd_port #(
                .DATA_W   (DATA_W),
                .ADDR_W   (ADDR_W),
                .RD_LAT   (RD_LAT),
                .WR_FIRST (WR_FIRST)
            ) u_rd_port (
                .clk       (clk),
                .rst_n     (rst_n),
                .rd_ena    (rd_ena[i]),
                .rd_addr   (port_addr),
                .ram_rdata (ram[port_addr]),
                .wr_accept (wr_accept),
                .wr_addr   (wr_addr),
                .wr_data   (wr_data),
                .clr_busy  (clr_busy),
                .q         (q[i*DATA_W +: DATA_W]),
                .dval      (dval[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_multiport_dram_sclk.sv
// Directed bench for multiport_dram_sclk. Two instances share the write and
// clear inputs: dut_a (4 ports, latency 2, write-first) and dut_b (2 ports,
// latency 1, read-old-data). Ports 0..1 of dut_b see the same read inputs as
// ports 0..1 of dut_a.
module tb_multiport_dram_sclk;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wr_ena = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [3:0]  rd_ena = '0;
    logic [15:0] rd_addr = '0;
    logic        clr_req = 1'b0;

    logic [63:0] q_a;
    logic [3:0]  dval_a;
    logic        clr_busy_a, clr_done_a, wr_drop_a;
    logic [31:0] q_b;
    logic [1:0]  dval_b;
    logic        clr_busy_b, clr_done_b, wr_drop_b;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] model [16];

    multiport_dram_sclk #(.DATA_W(16), .ADDR_W(4), .N_RD(4), .RD_LAT(2), .WR_FIRST(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_ena(rd_ena), .rd_addr(rd_addr), .q(q_a), .dval(dval_a),
        .clr_req(clr_req), .clr_busy(clr_busy_a), .clr_done(clr_done_a), .wr_drop(wr_drop_a)
    );

    multiport_dram_sclk #(.DATA_W(16), .ADDR_W(4), .N_RD(2), .RD_LAT(1), .WR_FIRST(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_ena(rd_ena[1:0]), .rd_addr(rd_addr[7:0]), .q(q_b), .dval(dval_b),
        .clr_req(clr_req), .clr_busy(clr_busy_b), .clr_done(clr_done_b), .wr_drop(wr_drop_b)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_rd(input logic [3:0] en, input logic [3:0] a0, input logic [3:0] a1,
                          input logic [3:0] a2, input logic [3:0] a3);
        rd_ena  = en;
        rd_addr = {a3, a2, a1, a0};
    endtask

    task automatic do_write(input logic [3:0] a, input logic [15:0] d);
        wr_ena  = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_ena  = 1'b0;
        model[a] = d;
    endtask

    initial begin
        logic [3:0]  base, ena, ena_d, wa;
        logic [3:0]  ad [4];
        logic [15:0] wd;
        logic        we;
        logic [15:0] exp_now [4];
        logic [15:0] exp_d [4];
        logic [15:0] expb [2];
        logic [15:0] hold_a [4];
        logic [15:0] hold_b [2];

        // asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #2;
        chk("rst_q_a", 64'(q_a), 64'h0);
        chk("rst_dval_a", 64'(dval_a), 64'h0);
        chk("rst_q_b", 64'(q_b), 64'h0);
        chk("rst_dval_b", 64'(dval_b), 64'h0);
        chk("rst_busy", 64'(clr_busy_a), 64'h0);
        chk("rst_done", 64'(clr_done_a), 64'h0);
        chk("rst_drop", 64'(wr_drop_a), 64'h0);
        #10 rst_n = 1'b1;
        tick();

        // fill the array with known data
        for (int k = 0; k < 16; k++) begin
            do_write(4'(k), 16'h0100 + 16'(k));
        end

        // write then read next cycle
        do_write(4'd3, 16'h1234);
        set_rd(4'b0001, 4'd3, 4'd0, 4'd0, 4'd0);
        tick();
        chk("lat1_q0", 64'(q_b[15:0]), 64'h1234);
        chk("lat1_dval", 64'(dval_b), 64'h1);
        chk("lat2_dval_early", 64'(dval_a), 64'h0);
        set_rd(4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
        tick();
        chk("lat2_q0", 64'(q_a[15:0]), 64'h1234);
        chk("lat2_dval", 64'(dval_a), 64'h1);
        chk("lat1_dval_off", 64'(dval_b), 64'h0);
        chk("lat1_q0_hold", 64'(q_b[15:0]), 64'h1234);

        // same-edge collision, ports 0 and 1 on the same address
        do_write(4'd5, 16'h0001);
        wr_ena = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
        set_rd(4'b0011, 4'd5, 4'd5, 4'd0, 4'd0);
        tick();
        wr_ena = 1'b0;
        model[5] = 16'hBEEF;
        chk("coll_rd_old_q1", 64'(q_b[31:16]), 64'h0001);
        chk("coll_rd_old_q0", 64'(q_b[15:0]), 64'h0001);
        set_rd(4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
        tick();
        chk("coll_wr_first_q1", 64'(q_a[31:16]), 64'hBEEF);
        chk("coll_wr_first_q0", 64'(q_a[15:0]), 64'hBEEF);
        chk("coll_dval_a", 64'(dval_a), 64'h3);
        set_rd(4'b0010, 4'd0, 4'd5, 4'd0, 4'd0);
        tick();
        set_rd(4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
        chk("coll_after_q1", 64'(q_b[31:16]), 64'hBEEF);
        tick();

        // scoreboard run: distinct addresses per port, random writes and enables
        ena_d = '0;
        for (int i = 0; i < 4; i++) begin
            exp_d[i] = '0;
            hold_a[i] = '0;
        end
        for (int i = 0; i < 2; i++) hold_b[i] = '0;
        for (int it = 0; it < 100; it++) begin
            base = 4'($urandom_range(0, 15));
            ena  = (it == 0) ? 4'hF : 4'($urandom_range(0, 15));
            we   = 1'($urandom_range(0, 1));
            wa   = 4'($urandom_range(0, 15));
            wd   = 16'($urandom);
            for (int i = 0; i < 4; i++) begin
                ad[i] = base + 4'(i);
                exp_now[i] = (we && wa == ad[i]) ? wd : model[ad[i]];
            end
            for (int i = 0; i < 2; i++) expb[i] = model[ad[i]];
            set_rd(ena, ad[0], ad[1], ad[2], ad[3]);
            wr_ena = we; wr_addr = wa; wr_data = wd;
            if (we) model[wa] = wd;
            tick();
            for (int i = 0; i < 2; i++) begin
                if (ena[i]) hold_b[i] = expb[i];
                chk($sformatf("sb_b_dval%0d", i), 64'(dval_b[i]), 64'(ena[i]));
                chk($sformatf("sb_b_q%0d", i), 64'(q_b[i*16 +: 16]), 64'(hold_b[i]));
            end
            if (it >= 1) begin
                for (int i = 0; i < 4; i++) begin
                    if (ena_d[i]) hold_a[i] = exp_d[i];
                    chk($sformatf("sb_a_dval%0d", i), 64'(dval_a[i]), 64'(ena_d[i]));
                    chk($sformatf("sb_a_q%0d", i), 64'(q_a[i*16 +: 16]), 64'(hold_a[i]));
                end
            end
            ena_d = ena;
            for (int i = 0; i < 4; i++) exp_d[i] = exp_now[i];
        end
        wr_ena = 1'b0;
        set_rd(4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
        tick();
        tick();

        // full clear sweep with a dropped write, an ignored request and a read
        do_write(4'd7, 16'h7007);
        chk("pre_clear_busy", 64'(clr_busy_a), 64'h0);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            chk($sformatf("clr_busy_c%0d", c), 64'(clr_busy_a), 64'h1);
            chk($sformatf("clr_done_c%0d", c), 64'(clr_done_a), 64'h0);
            if (c == 3) begin
                wr_ena = 1'b1; wr_addr = 4'd2; wr_data = 16'hAAAA;
            end
            if (c == 5) clr_req = 1'b1;
            if (c == 6) set_rd(4'b0001, 4'd7, 4'd0, 4'd0, 4'd0);
            tick();
            wr_ena  = 1'b0;
            clr_req = 1'b0;
            set_rd(4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
            if (c == 3) chk("wr_drop_pulse", 64'(wr_drop_a), 64'h1);
            if (c == 4) chk("wr_drop_end", 64'(wr_drop_a), 64'h0);
            if (c == 6) begin
                chk("clr_read_q", 64'(q_b[15:0]), 64'h0);
                chk("clr_read_dval", 64'(dval_b[0]), 64'h1);
            end
        end
        chk("done_pulse", 64'(clr_done_a), 64'h1);
        chk("done_busy", 64'(clr_busy_a), 64'h0);
        tick();
        chk("done_end", 64'(clr_done_a), 64'h0);
        chk("idle_busy", 64'(clr_busy_a), 64'h0);
        tick();
        chk("no_requeue", 64'(clr_busy_a), 64'h0);
        for (int k = 0; k < 16; k++) model[k] = '0;
        for (int g = 0; g < 4; g++) begin
            set_rd(4'hF, 4'(4*g), 4'(4*g+1), 4'(4*g+2), 4'(4*g+3));
            tick();
            set_rd(4'h0, 4'd0, 4'd0, 4'd0, 4'd0);
            tick();
            chk($sformatf("cleared_grp%0d", g), q_a, 64'h0);
            chk($sformatf("cleared_dval%0d", g), 64'(dval_a), 64'hF);
        end

        // reset in the middle of a sweep
        do_write(4'd10, 16'h5A5A);
        do_write(4'd12, 16'h7777);
        do_write(4'd2, 16'h2222);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            if (c == 7) set_rd(4'b0001, 4'd12, 4'd0, 4'd0, 4'd0);
            tick();
        end
        set_rd(4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
        chk("mid_busy_before", 64'(clr_busy_a), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(clr_busy_a), 64'h0);
        chk("mid_rst_done", 64'(clr_done_a), 64'h0);
        chk("mid_rst_dval", 64'(dval_a), 64'h0);
        #2 rst_n = 1'b1;
        tick();
        chk("lost_read_dval", 64'(dval_a), 64'h0);
        chk("post_rst_done", 64'(clr_done_a), 64'h0);
        chk("post_rst_busy", 64'(clr_busy_a), 64'h0);
        tick();
        chk("lost_read_dval2", 64'(dval_a), 64'h0);
        for (int k = 0; k < 7; k++) model[k] = '0;
        set_rd(4'hF, 4'd10, 4'd2, 4'd12, 4'd0);
        tick();
        set_rd(4'h0, 4'd0, 4'd0, 4'd0, 4'd0);
        chk("partial_b_q0", 64'(q_b[15:0]), 64'h5A5A);
        chk("partial_b_q1", 64'(q_b[31:16]), 64'h0);
        tick();
        chk("partial_a_q0", 64'(q_a[15:0]), 64'(model[10]));
        chk("partial_a_q1", 64'(q_a[31:16]), 64'(model[2]));
        chk("partial_a_q2", 64'(q_a[47:32]), 64'h7777);
        chk("partial_a_q3", 64'(q_a[63:48]), 64'h0);
        chk("partial_busy", 64'(clr_busy_a), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
